// File: rtl/aw_beat_gen.sv
`default_nettype none
// ============================================================================
//  Module      : aw_beat_gen
//  Description : Write-address beat generator on the read side of the AW
//                async FIFO. Pops one buffered AW request at a time and
//                expands it into a per-beat address stream (valid/ready,
//                last flag) for the W-channel merge stage.
//                Optional feature macro: AW_BEAT_GEN_WRAP_EN
//                  defined   -> WRAP bursts wrap inside their aligned window
//                  undefined -> WRAP hardware removed, WRAP treated as INCR
//  Revision    : 1.0 - initial release
// ============================================================================
module aw_beat_gen #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 4,
    parameter int SIZE_WIDTH = 3
) (
    input  logic                  clk_rx,
    input  logic                  nrst_rx,
    input  logic                  fifo_empty,
    output logic                  fifo_pop,
    input  logic [ID_WIDTH-1:0]   front_AWID,
    input  logic [ADDR_WIDTH-1:0] front_AWADDR,
    input  logic [LEN_WIDTH-1:0]  front_AWLEN,
    input  logic [SIZE_WIDTH-1:0] front_AWSIZE,
    input  logic [1:0]            front_AWBURST,
    output logic                  beat_valid,
    input  logic                  beat_ready,
    output logic [ID_WIDTH-1:0]   beat_id,
    output logic [ADDR_WIDTH-1:0] beat_addr,
    output logic [SIZE_WIDTH-1:0] beat_size,
    output logic                  beat_last,
    output logic                  busy
);

    localparam logic [1:0]            C_BURST_FIXED = 2'b00;
    localparam logic [ADDR_WIDTH-1:0] C_ADDR_ONE    = ADDR_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]  C_LEN_ONE     = LEN_WIDTH'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t                state_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [SIZE_WIDTH-1:0] size_q;
    logic [LEN_WIDTH-1:0]  cnt_q;
    logic [1:0]            burst_q;

    logic [ADDR_WIDTH-1:0] w_bytes;
    logic                  w_accept;
    logic                  w_cnt_zero;

`ifdef AW_BEAT_GEN_WRAP_EN
    localparam logic [1:0] C_BURST_WRAP = 2'b10;

    // Wrap window captured once per burst so the per-beat path is a single
    // add and compare.
    logic [ADDR_WIDTH-1:0] lower_q;
    logic [ADDR_WIDTH-1:0] wrap_bytes_q;
    logic [ADDR_WIDTH-1:0] w_front_wrap_bytes;
    logic [ADDR_WIDTH-1:0] w_front_lower;
    logic [ADDR_WIDTH-1:0] w_wrap_sum;

    // Window size = bytes per beat * beat count, base = start aligned to it.
    always_comb begin
        w_front_wrap_bytes = ({{(ADDR_WIDTH-LEN_WIDTH){1'b0}}, front_AWLEN} + C_ADDR_ONE)
                             << front_AWSIZE;
        w_front_lower      = front_AWADDR & ~(w_front_wrap_bytes - C_ADDR_ONE);
    end
`endif

    assign w_bytes    = C_ADDR_ONE << size_q;
    assign w_cnt_zero = (cnt_q == '0);
    assign w_accept   = (state_q == ST_BURST) && beat_ready;

    // Pop when idle with data waiting, or on the last-beat accept so the next
    // burst follows without a bubble. Gated by reset so nothing leaves the
    // FIFO while the block is held in reset.
    assign fifo_pop = nrst_rx && !fifo_empty &&
                      ((state_q == ST_IDLE) || (w_accept && w_cnt_zero));

    assign busy       = (state_q == ST_BURST);
    assign beat_valid = (state_q == ST_BURST);
    assign beat_last  = (state_q == ST_BURST) && w_cnt_zero;
    assign beat_id    = id_q;
    assign beat_addr  = addr_q;
    assign beat_size  = size_q;

    // Next beat address: FIXED holds, INCR steps from the aligned address
    // (so only the first beat can be unaligned), WRAP folds back to the base.
    always_comb begin
        addr_d = (addr_q & ~(w_bytes - C_ADDR_ONE)) + w_bytes;
`ifdef AW_BEAT_GEN_WRAP_EN
        w_wrap_sum = addr_q + w_bytes;
`endif
        if (burst_q == C_BURST_FIXED) begin
            addr_d = addr_q;
        end
`ifdef AW_BEAT_GEN_WRAP_EN
        else if (burst_q == C_BURST_WRAP) begin
            addr_d = (w_wrap_sum == (lower_q + wrap_bytes_q)) ? lower_q : w_wrap_sum;
        end
`endif
    end

    // Burst FSM: load on pop, step counter/address on each accepted beat.
    always_ff @(posedge clk_rx or negedge nrst_rx) begin
        if (!nrst_rx) begin
            state_q      <= ST_IDLE;
            id_q         <= '0;
            addr_q       <= '0;
            size_q       <= '0;
            cnt_q        <= '0;
            burst_q      <= '0;
`ifdef AW_BEAT_GEN_WRAP_EN
            lower_q      <= '0;
            wrap_bytes_q <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        state_q      <= ST_BURST;
                        id_q         <= front_AWID;
                        addr_q       <= front_AWADDR;
                        size_q       <= front_AWSIZE;
                        cnt_q        <= front_AWLEN;
                        burst_q      <= front_AWBURST;
`ifdef AW_BEAT_GEN_WRAP_EN
                        lower_q      <= w_front_lower;
                        wrap_bytes_q <= w_front_wrap_bytes;
`endif
                    end
                end
                ST_BURST: begin
                    if (w_accept) begin
                        if (w_cnt_zero) begin
                            if (fifo_pop) begin
                                id_q         <= front_AWID;
                                addr_q       <= front_AWADDR;
                                size_q       <= front_AWSIZE;
                                cnt_q        <= front_AWLEN;
                                burst_q      <= front_AWBURST;
`ifdef AW_BEAT_GEN_WRAP_EN
                                lower_q      <= w_front_lower;
                                wrap_bytes_q <= w_front_wrap_bytes;
`endif
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            cnt_q  <= cnt_q - C_LEN_ONE;
                            addr_q <= addr_d;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aw_beat_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aw_beat_gen
//  Description : Self-checking bench for aw_beat_gen. FIFO front is modelled
//                by an array; expected beats are computed per burst from the
//                addressing rules and compared on each accepted beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aw_beat_gen;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } entry_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [2:0]  size;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [31:0]      addr;
        logic [3:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic [2:0]       n;
        logic [3:0][31:0] exp;
    } vec_t;

    logic        clk_rx = 1'b0;
    logic        nrst_rx = 1'b0;
    logic        fifo_empty;
    logic        fifo_pop;
    logic [3:0]  front_AWID;
    logic [31:0] front_AWADDR;
    logic [3:0]  front_AWLEN;
    logic [2:0]  front_AWSIZE;
    logic [1:0]  front_AWBURST;
    logic        beat_valid;
    logic        beat_ready = 1'b0;
    logic [3:0]  beat_id;
    logic [31:0] beat_addr;
    logic [2:0]  beat_size;
    logic        beat_last;
    logic        busy;

    entry_t      fifo_mem [0:255];
    logic [7:0]  rd_ptr = '0;
    logic [7:0]  wr_ptr = '0;

    beat_t       exp_q[$];
    logic [31:0] cap_addr[$];
    logic [3:0]  cap_id[$];
    logic        cap_last[$];
    int          cap_cyc[$];
    logic        cap_pop[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic        stall_q = 1'b0;
    beat_t       hold_b;

    assign fifo_empty    = (rd_ptr == wr_ptr);
    assign front_AWID    = fifo_mem[rd_ptr].id;
    assign front_AWADDR  = fifo_mem[rd_ptr].addr;
    assign front_AWLEN   = fifo_mem[rd_ptr].len;
    assign front_AWSIZE  = fifo_mem[rd_ptr].size;
    assign front_AWBURST = fifo_mem[rd_ptr].burst;

    aw_beat_gen #(
        .ID_WIDTH   (4),
        .ADDR_WIDTH (32),
        .LEN_WIDTH  (4),
        .SIZE_WIDTH (3)
    ) dut (
        .clk_rx        (clk_rx),
        .nrst_rx       (nrst_rx),
        .fifo_empty    (fifo_empty),
        .fifo_pop      (fifo_pop),
        .front_AWID    (front_AWID),
        .front_AWADDR  (front_AWADDR),
        .front_AWLEN   (front_AWLEN),
        .front_AWSIZE  (front_AWSIZE),
        .front_AWBURST (front_AWBURST),
        .beat_valid    (beat_valid),
        .beat_ready    (beat_ready),
        .beat_id       (beat_id),
        .beat_addr     (beat_addr),
        .beat_size     (beat_size),
        .beat_last     (beat_last),
        .busy          (busy)
    );

    always #5 clk_rx = ~clk_rx;

    always @(posedge clk_rx) begin
        cyc <= cyc + 1;
        if (fifo_pop) rd_ptr <= rd_ptr + 8'd1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    // Address of beat i from the burst rules in closed form.
    function automatic logic [31:0] model_addr(input entry_t e, input int i);
        logic [31:0] bytes;
        logic [31:0] wb;
        logic [31:0] lower;
        bytes = 32'd1 << e.size;
        if (e.burst == 2'b00) return e.addr;
`ifdef AW_BEAT_GEN_WRAP_EN
        if (e.burst == 2'b10) begin
            wb    = bytes * (32'(e.len) + 32'd1);
            lower = e.addr & ~(wb - 32'd1);
            return lower + ((e.addr - lower + 32'(i) * bytes) % wb);
        end
`endif
        wb    = 32'd0;
        lower = 32'd0;
        if (i == 0) return e.addr;
        return (e.addr & ~(bytes - 32'd1)) + 32'(i) * bytes;
    endfunction

    task automatic push(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
        entry_t e;
        beat_t  b;
        e = '{id: id, addr: addr, len: len, size: size, burst: burst};
        fifo_mem[wr_ptr] = e;
        wr_ptr = wr_ptr + 8'd1;
        for (int i = 0; i <= int'(len); i++) begin
            b.id   = id;
            b.addr = model_addr(e, i);
            b.size = size;
            b.last = (i == int'(len));
            exp_q.push_back(b);
        end
    endtask

    task automatic clear_caps();
        cap_addr.delete(); cap_id.delete(); cap_last.delete(); cap_cyc.delete(); cap_pop.delete();
    endtask

    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget; k++) begin
            if (exp_q.size() == 0 && fifo_empty && !busy) return;
            @(posedge clk_rx); #1;
        end
        chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    // Beat monitor: checks accepted beats against the model and holds stable
    // while stalled.
    always @(negedge clk_rx) begin
        beat_t e;
        if (!nrst_rx) begin
            stall_q = 1'b0;
        end else begin
            if (fifo_pop) chk("pop_when_empty", 64'(fifo_empty), 64'd0);
            if (stall_q) begin
                chk("hold_valid", 64'(beat_valid), 64'd1);
                chk("hold_id",    64'(beat_id),    64'(hold_b.id));
                chk("hold_addr",  64'(beat_addr),  64'(hold_b.addr));
                chk("hold_size",  64'(beat_size),  64'(hold_b.size));
                chk("hold_last",  64'(beat_last),  64'(hold_b.last));
            end
            if (beat_valid && beat_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL extra_beat: got addr 0x%0h, expected no beat", beat_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_id",   64'(beat_id),   64'(e.id));
                    chk("beat_addr", 64'(beat_addr), 64'(e.addr));
                    chk("beat_size", 64'(beat_size), 64'(e.size));
                    chk("beat_last", 64'(beat_last), 64'(e.last));
                end
                cap_addr.push_back(beat_addr);
                cap_id.push_back(beat_id);
                cap_last.push_back(beat_last);
                cap_cyc.push_back(cyc);
                cap_pop.push_back(fifo_pop);
            end
            stall_q = beat_valid && !beat_ready;
            hold_b  = '{id: beat_id, addr: beat_addr, size: beat_size, last: beat_last};
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [5];
        logic pat [6];
        int   k;

        vecs[0] = '{addr: 32'h0000_1003, len: 4'd3, size: 3'd2, burst: 2'b01, n: 3'd4,
                    exp: {32'h0000_100C, 32'h0000_1008, 32'h0000_1004, 32'h0000_1003}};
`ifdef AW_BEAT_GEN_WRAP_EN
        vecs[1] = '{addr: 32'h0000_0034, len: 4'd3, size: 3'd2, burst: 2'b10, n: 3'd4,
                    exp: {32'h0000_0030, 32'h0000_003C, 32'h0000_0038, 32'h0000_0034}};
`else
        vecs[1] = '{addr: 32'h0000_0034, len: 4'd3, size: 3'd2, burst: 2'b10, n: 3'd4,
                    exp: {32'h0000_0040, 32'h0000_003C, 32'h0000_0038, 32'h0000_0034}};
`endif
        vecs[2] = '{addr: 32'hFFFF_FFFC, len: 4'd1, size: 3'd2, burst: 2'b01, n: 3'd2,
                    exp: {32'h0, 32'h0, 32'h0000_0000, 32'hFFFF_FFFC}};
        vecs[3] = '{addr: 32'h0000_0010, len: 4'd2, size: 3'd0, burst: 2'b11, n: 3'd3,
                    exp: {32'h0, 32'h0000_0012, 32'h0000_0011, 32'h0000_0010}};
        vecs[4] = '{addr: 32'h0000_0055, len: 4'd0, size: 3'd1, burst: 2'b01, n: 3'd1,
                    exp: {32'h0, 32'h0, 32'h0, 32'h0000_0055}};

        // Reset state
        #12;
        chk("rst_valid", 64'(beat_valid), 64'd0);
        chk("rst_busy",  64'(busy),       64'd0);
        chk("rst_last",  64'(beat_last),  64'd0);
        chk("rst_pop",   64'(fifo_pop),   64'd0);
        chk("rst_addr",  64'(beat_addr),  64'd0);
        chk("rst_id",    64'(beat_id),    64'd0);
        chk("rst_size",  64'(beat_size),  64'd0);
        @(posedge clk_rx); #1;
        nrst_rx = 1'b1;
        @(posedge clk_rx); #1;

        // Directed vector table, ready held high
        foreach (vecs[v]) begin
            clear_caps();
            beat_ready = 1'b1;
            push(4'(v + 3), vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst);
            wait_idle(100);
            chk($sformatf("vec%0d_beats", v), 64'(cap_addr.size()), 64'(vecs[v].n));
            for (int i = 0; i < int'(vecs[v].n) && i < cap_addr.size(); i++) begin
                chk($sformatf("vec%0d_addr%0d", v, i), 64'(cap_addr[i]), 64'(vecs[v].exp[i]));
                chk($sformatf("vec%0d_last%0d", v, i), 64'(cap_last[i]), 64'(i == int'(vecs[v].n) - 1));
            end
        end

        // FIXED with backpressure
        beat_ready = 1'b0;
        clear_caps();
        push(4'd7, 32'h0000_2000, 4'd2, 3'd3, 2'b00);
        k = 0;
        while (!busy && k < 10) begin @(posedge clk_rx); #1; k++; end
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            beat_ready = pat[i];
            @(posedge clk_rx); #1;
        end
        beat_ready = 1'b0;
        wait_idle(20);
        chk("fixed_beats", 64'(cap_addr.size()), 64'd3);
        for (int i = 0; i < 3 && i < cap_addr.size(); i++) begin
            chk($sformatf("fixed_addr%0d", i), 64'(cap_addr[i]), 64'h2000);
            chk($sformatf("fixed_last%0d", i), 64'(cap_last[i]), 64'(i == 2));
        end

        // Latency and back-to-back bursts
        clear_caps();
        push(4'd1, 32'h0000_0100, 4'd1, 3'd2, 2'b01);
        push(4'd2, 32'h0000_0200, 4'd0, 3'd2, 2'b01);
        #1;
        chk("lat_pop",        64'(fifo_pop),   64'd1);
        chk("lat_valid_pre",  64'(beat_valid), 64'd0);
        @(posedge clk_rx); #1;
        chk("lat_valid_post", 64'(beat_valid), 64'd1);
        beat_ready = 1'b1;
        wait_idle(20);
        chk("b2b_beats", 64'(cap_id.size()), 64'd3);
        if (cap_id.size() == 3) begin
            chk("b2b_id0",   64'(cap_id[0]),   64'd1);
            chk("b2b_id1",   64'(cap_id[1]),   64'd1);
            chk("b2b_id2",   64'(cap_id[2]),   64'd2);
            chk("b2b_last1", 64'(cap_last[1]), 64'd1);
            chk("b2b_last2", 64'(cap_last[2]), 64'd1);
            chk("b2b_gap1",  64'(cap_cyc[1] - cap_cyc[0]), 64'd1);
            chk("b2b_gap2",  64'(cap_cyc[2] - cap_cyc[1]), 64'd1);
            chk("b2b_pop",   64'(cap_pop[1]),  64'd1);
        end

        // Reset mid-burst
        clear_caps();
        beat_ready = 1'b1;
        push(4'd9, 32'h0000_0400, 4'd7, 3'd2, 2'b01);
        k = 0;
        while (cap_addr.size() < 3 && k < 20) begin @(posedge clk_rx); #1; k++; end
        chk("mid_beats_before_rst", 64'(cap_addr.size()), 64'd3);
        #1;
        nrst_rx = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_rst_valid", 64'(beat_valid), 64'd0);
        chk("mid_rst_busy",  64'(busy),       64'd0);
        chk("mid_rst_last",  64'(beat_last),  64'd0);
        chk("mid_rst_addr",  64'(beat_addr),  64'd0);
        chk("mid_rst_id",    64'(beat_id),    64'd0);
        @(posedge clk_rx); #1;
        nrst_rx = 1'b1;
        clear_caps();
        push(4'd5, 32'h0000_0040, 4'd1, 3'd2, 2'b01);
        wait_idle(20);
        chk("post_rst_beats", 64'(cap_addr.size()), 64'd2);
        if (cap_addr.size() == 2) begin
            chk("post_rst_addr0", 64'(cap_addr[0]), 64'h40);
            chk("post_rst_addr1", 64'(cap_addr[1]), 64'h44);
            chk("post_rst_id",    64'(cap_id[0]),   64'd5);
        end

        // Randomized bursts with random backpressure
        for (int n = 0; n < 80; n++) begin
            logic [2:0]  sz;
            logic [1:0]  bt;
            logic [3:0]  ln;
            logic [31:0] ad;
            repeat ($urandom_range(0, 3)) begin
                beat_ready = ($urandom_range(0, 3) != 0);
                @(posedge clk_rx); #1;
            end
            sz = 3'($urandom_range(0, 7));
            bt = 2'($urandom_range(0, 3));
            ln = 4'($urandom_range(0, 15));
            ad = $urandom;
            if (n % 16 == 5) ad = 32'hFFFF_FF00 | (ad & 32'hFF);
            if (bt == 2'b10) begin
                ln = 4'((1 << $urandom_range(1, 4)) - 1);
                ad = ad & ~((32'd1 << sz) - 32'd1);
            end
            push(4'($urandom_range(0, 15)), ad, ln, sz, bt);
        end
        for (int i = 0; i < 3000 && !(exp_q.size() == 0 && fifo_empty && !busy); i++) begin
            beat_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk_rx); #1;
        end
        beat_ready = 1'b1;
        wait_idle(200);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aw_beat_gen.md
# aw_beat_gen

Write-address beat generator on the consumer side of the AW async FIFO. Pops one buffered AW request (ID, address, length, size, burst) at a time and expands it into a per-beat address stream with valid/ready handshake and last flag. The downstream W-channel merge stage uses this stream to address each write data beat. Runs entirely in the FIFO's read-side clock domain.

## Interface
- ID_WIDTH, 4, AWID width
- ADDR_WIDTH, 32, address width
- LEN_WIDTH, 4, AWLEN width (beats = AWLEN+1, max 16)
- SIZE_WIDTH, 3, AWSIZE width (bytes per beat = 1<<AWSIZE)

- clk_rx  in  1  clock
- nrst_rx  in  1  reset, asynchronous, active-low
- fifo_empty  in  1  AW FIFO empty
- fifo_pop  out  1  pop pulse to AW FIFO; front entry is valid whenever fifo_empty=0
- front_AWID  in  ID_WIDTH  FIFO front ID
- front_AWADDR  in  ADDR_WIDTH  FIFO front start address
- front_AWLEN  in  LEN_WIDTH  FIFO front length
- front_AWSIZE  in  SIZE_WIDTH  FIFO front size
- front_AWBURST  in  2  FIFO front burst type (00 FIXED, 01 INCR, 10 WRAP, 11 reserved)
- beat_valid  out  1  beat address valid
- beat_ready  in  1  downstream accepts beat
- beat_id  out  ID_WIDTH  ID of current burst
- beat_addr  out  ADDR_WIDTH  address of current beat
- beat_size  out  SIZE_WIDTH  size of current burst
- beat_last  out  1  current beat is final beat of burst
- busy  out  1  a burst is in progress

## Operation
- States: IDLE, BURST.
- IDLE: if fifo_empty=0, assert fifo_pop (combinational, one cycle), latch front fields into burst registers, load beat counter = front_AWLEN, go to BURST. Else stay.
- BURST: beat_valid=1. On beat_valid && beat_ready: if counter==0 (last beat), then if fifo_empty=0, pop and load next burst, remain BURST (no bubble); else go IDLE. Otherwise decrement counter and advance address.
- beat_last = (state==BURST) && (counter==0).
- Address update, all arithmetic modulo 2^ADDR_WIDTH, carry discarded:
  - FIXED: address unchanged.
  - INCR / reserved 11: next = (addr & ~(bytes-1)) + bytes; first beat uses unaligned start address, later beats aligned.
  - WRAP: wrap_bytes = bytes*(AWLEN+1); lower = start & ~(wrap_bytes-1); next = addr+bytes; if next == lower+wrap_bytes then next = lower. lower and wrap_bytes computed once at load.
- No 4 KB boundary checking; upstream guarantees legal bursts.
- fifo_pop is never asserted while fifo_empty=1.

## Timing
- Reset (nrst_rx low, asynchronous): state IDLE; beat_valid, beat_last, busy, fifo_pop = 0; beat_id, beat_addr, beat_size, counter = 0. Reset mid-burst drops remaining beats; popped entry is not restored.
- Latency: fifo_empty falls at edge N → fifo_pop high in cycle N → beat_valid high from edge N+1.
- Sustained throughput: one beat per cycle while beat_ready=1, including across burst boundaries.
- Handshake: once beat_valid=1, beat_id/addr/size/last hold stable until accepted; beat_valid never drops without acceptance except by reset.
- busy = (state==BURST).
- Single-beat burst (AWLEN=0): beat_last=1 on the first beat.

## Configuration
- AW_BEAT_GEN_WRAP_EN: defined → WRAP addressing as above. Undefined → WRAP logic and lower/wrap_bytes registers are removed; burst type 10 is treated as INCR.

## Test plan
- Reset mid-burst: INCR AWLEN=7, reset after 3 beats → all outputs 0 immediately, state IDLE; next FIFO entry starts cleanly.
- INCR unaligned: ADDR=0x1003, SIZE=2, LEN=3, ready=1 → addrs 0x1003, 0x1004, 0x1008, 0x100C; last on beat 4; pop once.
- WRAP (macro defined): ADDR=0x0034, SIZE=2, LEN=3 → 0x34, 0x38, 0x3C, 0x30. Macro undefined → 0x34, 0x38, 0x3C, 0x40.
- FIXED with backpressure: ADDR=0x2000, SIZE=3, LEN=2, ready toggling 1,0,0,1,0,1 → addr stays 0x2000 and stable while stalled; 3 accepts; last on third.
- Back-to-back: two queued bursts (ID=1 LEN=1, ID=2 LEN=0), ready=1 → beats ID1,ID1(last),ID2(last) in consecutive cycles; second pop coincides with ID1 last accept.
- Address wrap-around: INCR ADDR=0xFFFFFFFC, SIZE=2, LEN=1 → 0xFFFFFFFC, 0x00000000.
